rf_write_arbiter: RTL

- Shares the single register-file write port (Reg_Write / Reg_write_ad / Reg_write_data) between NREQ writeback requesters, e.g. ALU, load unit and debug.
- Uses round-robin arbitration with a req/grant handshake.
- Registers the winning write for one cycle before driving the register file.
- Flags read-after-write hazards against the two register-file read addresses, with forward data, so the decode stage can bypass.

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rf_write_arbiter_if.sv | 31 +++
 rtl/rr_pick.sv | 29 ++
 rtl/rf_write_arbiter.sv | 72 +++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants and helpers for the register-file write arbiter.
package rf_arb_pkg;
    localparam int RF_N    = 16;
    localparam int RF_M    = 3;
    localparam int RF_NREQ = 3;
    localparam int PTR_W   = $clog2(RF_NREQ);

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r |= oh[i] ? 3'(i) : 3'd0;
        return r;
    endfunction
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester bus, committed write port and hazard lookup of the RF write arbiter.
interface rf_write_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int N    = RF_N,
    parameter int M    = RF_M,
    parameter int NREQ = RF_NREQ
);
    logic [NREQ-1:0]   Req;
    logic [NREQ*M-1:0] Req_ad;
    logic [NREQ*N-1:0] Req_data;
    logic [NREQ-1:0]   Grant;
    logic              Wr_hold;
    logic              Reg_Write;
    logic [M-1:0]      Reg_write_ad;
    logic [N-1:0]      Reg_write_data;
    logic [M-1:0]      Reg_read_ad_1;
    logic [M-1:0]      Reg_read_ad_2;
    logic              Hazard_1;
    logic              Hazard_2;
    logic [N-1:0]      Fwd_data;

    modport master (
        output Req, Req_ad, Req_data, Wr_hold, Reg_read_ad_1, Reg_read_ad_2,
        input  Grant, Reg_Write, Reg_write_ad, Reg_write_data, Hazard_1, Hazard_2, Fwd_data
    );
    modport slave (
        input  Req, Req_ad, Req_data, Wr_hold, Reg_read_ad_1, Reg_read_ad_2,
        output Grant, Reg_Write, Reg_write_ad, Reg_write_data, Hazard_1, Hazard_2, Fwd_data
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational one-hot picker, round-robin from ptr or, with RF_ARB_FIXED_PRIO_EN, lowest index.
module rr_pick
    import rf_arb_pkg::*;
#(
    parameter int NREQ = RF_NREQ,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
`ifndef RF_ARB_FIXED_PRIO_EN
    input  logic [PW-1:0]   ptr,
`endif
    input  logic            hold,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);
    always_comb begin
        grant = '0;
        // scan from the far end so the candidate closest to the start wins last
        for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            if (!hold && req[k]) grant = NREQ'(1) << k;
`else
            if (!hold && req[(int'(ptr) + k) % NREQ]) grant = NREQ'(1) << ((int'(ptr) + k) % NREQ);
`endif
        end
    end

    assign idx = PW'(oh2idx(8'(grant)));
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares one RF write port among NREQ requesters, commits the winner after one cycle, flags RAW hazards.
// Build option RF_ARB_FIXED_PRIO_EN replaces round-robin with fixed lowest-index priority.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N    = RF_N,
    parameter int M    = RF_M,
    parameter int NREQ = RF_NREQ
) (
    input logic               Clock,
    input logic               Reset,
    rf_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   idx;
    logic            xfer, we, we_q, we_d;
    logic [M-1:0]    ad_q, ad_d;
    logic [N-1:0]    data_q, data_d;
`ifndef RF_ARB_FIXED_PRIO_EN
    logic [PW-1:0]   ptr_q, ptr_d;
`endif

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req   (bus.Req),
`ifndef RF_ARB_FIXED_PRIO_EN
        .ptr   (ptr_q),
`endif
        .hold  (bus.Wr_hold | Reset),
        .grant (grant),
        .idx   (idx)
    );

    always_comb begin
        xfer   = |grant;
        we_d   = xfer;
        ad_d   = xfer ? bus.Req_ad[idx*M +: M] : ad_q;
        data_d = xfer ? bus.Req_data[idx*N +: N] : data_q;
`ifndef RF_ARB_FIXED_PRIO_EN
        ptr_d  = xfer ? ((idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            we_q   <= 1'b0;
            ad_q   <= '0;
            data_q <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr_q  <= '0;
`endif
        end else begin
            we_q   <= we_d;
            ad_q   <= ad_d;
            data_q <= data_d;
`ifndef RF_ARB_FIXED_PRIO_EN
            ptr_q  <= ptr_d;
`endif
        end
    end

    // masking with Reset drops a write still in flight when reset arrives
    assign we                 = we_q & ~Reset;
    assign bus.Grant          = grant;
    assign bus.Reg_Write      = we;
    assign bus.Reg_write_ad   = ad_q;
    assign bus.Reg_write_data = data_q;
    assign bus.Hazard_1       = we & (ad_q == bus.Reg_read_ad_1);
    assign bus.Hazard_2       = we & (ad_q == bus.Reg_read_ad_2);
    assign bus.Fwd_data       = data_q;
endmodule
